int_requester: RTL and testbench

- Device-side end of the CPU vectored-interrupt handshake. It collects completion events from up to four peripherals (done lines), arbitrates them by fixed priority, and raises interrupt toward the core.
- It presents the winning source's vector address on int_addr, holds it until int_ack, then waits for end-of-interrupt (eoi) before issuing the next request.
- Sits between the peripheral done strobes and the core's interrupt/int_ack/int_addr inputs.

---
 rtl/int_req_pkg.sv | 21 ++
 rtl/int_prio_enc.sv | 25 ++
 rtl/int_requester.sv | 120 ++++++++++++
 tb/tb_int_requester.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_req_pkg.sv
// Shared types and defaults for the vectored interrupt requester.
// State encoding, default vector layout and source index width.
package int_req_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;
    localparam int          IDX_W          = 2;

    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [IDX_W-1:0] idx);
        return base + (32'(idx) * stride);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible pending sources.
// Purely combinational, no backpressure.
module int_prio_enc
    import int_req_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] eligible,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        // Scan downward so the lowest set index is the last to write.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_requester.sv
// Device-side vectored interrupt requester: edge-latched sources, fixed priority, ack/eoi handshake.
// Event to interrupt in two edges; one request in flight, new events wait. Optional INT_REQ_MASK_EN.
module int_requester
    import int_req_pkg::*;
#(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] done,
    input  logic             int_ack,
    input  logic             eoi,
`ifdef INT_REQ_MASK_EN
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
`endif
    output logic             interrupt,
    output logic [31:0]      int_addr,
    output logic [IDX_W-1:0] int_id,
    output logic [N_SRC-1:0] pending
);

    state_t             state_q;
    state_t             state_d;
    logic [N_SRC-1:0]   done_q;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   clr;
    logic [N_SRC-1:0]   pending_d;
    logic               interrupt_d;
    logic [31:0]        addr_d;
    logic [IDX_W-1:0]   id_d;
    logic               arb_vld;
    logic [IDX_W-1:0]   arb_idx;

    assign rise = done & ~done_q;

`ifdef INT_REQ_MASK_EN
    logic [N_SRC-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q <= '1;
        end else if (mask_we) begin
            mask_q <= mask_wdata;
        end
    end

    assign eligible = pending & mask_q;
`else
    assign eligible = pending;
`endif

    int_prio_enc #(
        .N_SRC    (N_SRC)
    ) u_prio_enc (
        .eligible (eligible),
        .vld      (arb_vld),
        .idx      (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt;
        addr_d      = int_addr;
        id_d        = int_id;
        clr         = '0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d     = REQ;
                    interrupt_d = 1'b1;
                    id_d        = arb_idx;
                    addr_d      = vec_addr(VEC_BASE, VEC_STRIDE, arb_idx);
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d     = SERVICE;
                    interrupt_d = 1'b0;
                    for (int i = 0; i < N_SRC; i++) begin
                        clr[i] = (IDX_W'(i) == int_id);
                    end
                end
            end
            SERVICE: begin
                interrupt_d = 1'b0;
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                interrupt_d = 1'b0;
            end
        endcase
        // A rise on the bit being cleared keeps it: the new event must not be lost.
        pending_d = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        done_q <= done;
        if (!reset) begin
            state_q   <= IDLE;
            interrupt <= 1'b0;
            int_addr  <= '0;
            int_id    <= '0;
            pending   <= '0;
        end else begin
            state_q   <= state_d;
            interrupt <= interrupt_d;
            int_addr  <= addr_d;
            int_id    <= id_d;
            pending   <= pending_d;
        end
    end

endmodule

// File: tb/tb_int_requester.sv
// Self-checking bench: directed handshake scenarios plus randomized traffic against a behavioural model.
module tb_int_requester;

    localparam int          N   = 4;
    localparam logic [31:0] VB  = 32'h0000_0100;
    localparam logic [31:0] VS  = 32'h0000_0010;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] done;
    logic         int_ack;
    logic         eoi;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         interrupt;
    logic [31:0]  int_addr;
    logic [1:0]   int_id;
    logic [N-1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: which request (if any) is outstanding and what is latched.
    logic [N-1:0] m_prev_done;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_mask;
    int           m_phase;   // 0 waiting for work, 1 awaiting ack, 2 awaiting eoi
    logic         m_int;
    logic [31:0]  m_addr;
    logic [1:0]   m_id;

    always #5 clk = ~clk;

    int_requester #(
        .N_SRC      (N),
        .VEC_BASE   (VB),
        .VEC_STRIDE (VS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .done       (done),
        .int_ack    (int_ack),
        .eoi        (eoi),
`ifdef INT_REQ_MASK_EN
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
`endif
        .interrupt  (interrupt),
        .int_addr   (int_addr),
        .int_id     (int_id),
        .pending    (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] rise;
        logic [N-1:0] mask_now;
        if (!reset) begin
            m_phase = 0; m_int = 0; m_addr = 0; m_id = 0; m_pend = 0;
            m_prev_done = done;
            m_mask = '1;
        end else begin
            rise = done & ~m_prev_done;
            m_prev_done = done;
`ifdef INT_REQ_MASK_EN
            mask_now = m_mask;
            if (mask_we) m_mask = mask_wdata;
`else
            mask_now = '1;
`endif
            if (m_phase == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_phase == 0 && m_pend[i] && mask_now[i]) begin
                        m_phase = 1; m_int = 1; m_id = 2'(i);
                        m_addr = VB + i * VS;
                    end
                end
            end else if (m_phase == 1) begin
                if (int_ack) begin
                    m_pend[m_id] = 1'b0;
                    m_phase = 2; m_int = 0;
                end
            end else begin
                if (eoi) m_phase = 0;
            end
            m_pend = m_pend | rise;
        end
    endtask

    // Advance one edge, update the model with the inputs the DUT sampled, compare just after.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("interrupt", 32'(interrupt), 32'(m_int));
        chk("int_addr",  int_addr,       m_addr);
        chk("int_id",    32'(int_id),    32'(m_id));
        chk("pending",   32'(pending),   32'(m_pend));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_int(input int budget);
        int k = 0;
        while (interrupt !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        if (interrupt !== 1'b1) chk("wait_int_timeout", 32'(interrupt), 32'd1);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; step(); int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; step(); eoi = 1'b0;
    endtask

    task automatic rise_src(input logic [N-1:0] bits);
        done = done | bits; step(); done = done & ~bits;
    endtask

    initial begin
        reset = 1'b0; done = '0; int_ack = 1'b0; eoi = 1'b0;
        mask_we = 1'b0; mask_wdata = '0;
        steps(3);
        chk("reset_interrupt", 32'(interrupt), 32'd0);
        chk("reset_addr",      int_addr,       32'd0);
        chk("reset_pending",   32'(pending),   32'd0);
        reset = 1'b1;
        steps(2);

        // Single event on source 2: pending at first edge, interrupt at the second.
        done = 4'b0100; step();
        chk("single_pend", 32'(pending), 32'h4);
        chk("single_noint_yet", 32'(interrupt), 32'd0);
        done = '0; step();
        chk("single_int", 32'(interrupt), 32'd1);
        chk("single_addr", int_addr, 32'h0000_0120);
        chk("single_id", 32'(int_id), 32'd2);
        steps(2);
        pulse_ack();
        chk("single_ack_int", 32'(interrupt), 32'd0);
        chk("single_ack_pend", 32'(pending), 32'd0);
        steps(2);
        pulse_eoi();
        steps(3);
        chk("single_idle_int", 32'(interrupt), 32'd0);

        // Priority between simultaneous rises on 3 and 1, with a low gap between requests.
        rise_src(4'b1010);
        wait_int(5);
        chk("prio_first", int_addr, 32'h0000_0110);
        pulse_ack();
        pulse_eoi();
        chk("prio_gap", 32'(interrupt), 32'd0);
        step();
        chk("prio_second_int", 32'(interrupt), 32'd1);
        chk("prio_second", int_addr, 32'h0000_0130);
        pulse_ack();
        pulse_eoi();
        steps(2);

        // No preemption: source 0 arrives while source 2 is requested.
        rise_src(4'b0100);
        wait_int(5);
        rise_src(4'b0001);
        steps(2);
        chk("nopreempt_hold", int_addr, 32'h0000_0120);
        pulse_ack();
        pulse_eoi();
        wait_int(5);
        chk("nopreempt_next", int_addr, 32'h0000_0100);
        pulse_ack();
        pulse_eoi();
        steps(2);

        // Line held high through reset must not count as an event.
        done = 4'b0010; reset = 1'b0; steps(2);
        reset = 1'b1; steps(4);
        chk("rst_held_int", 32'(interrupt), 32'd0);
        chk("rst_held_pend", 32'(pending), 32'd0);
        done = '0; steps(2);

        // Reset while in service drops everything.
        rise_src(4'b1000);
        wait_int(5);
        pulse_ack();
        steps(2);
        reset = 1'b0; step();
        chk("rst_svc_int", 32'(interrupt), 32'd0);
        chk("rst_svc_addr", int_addr, 32'd0);
        chk("rst_svc_id", 32'(int_id), 32'd0);
        chk("rst_svc_pend", 32'(pending), 32'd0);
        reset = 1'b1; steps(2);

        // Spurious ack/eoi in idle, then repeated rises on 0 collapse into one request.
        pulse_ack(); pulse_eoi();
        chk("spur_idle_int", 32'(interrupt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            done = 4'b0001; step();
            done = '0; step();
        end
        chk("collapse_int", 32'(interrupt), 32'd1);
        pulse_eoi();
        chk("eoi_in_req_ignored", 32'(interrupt), 32'd1);
        pulse_ack();
        chk("collapse_pend", 32'(pending), 32'd0);
        pulse_eoi();
        steps(5);
        chk("collapse_single", 32'(interrupt), 32'd0);

`ifdef INT_REQ_MASK_EN
        mask_we = 1'b1; mask_wdata = 4'b1110; step(); mask_we = 1'b0;
        rise_src(4'b0001);
        steps(4);
        chk("mask_pend", 32'(pending), 32'h1);
        chk("mask_noint", 32'(interrupt), 32'd0);
        mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
        wait_int(5);
        chk("unmask_addr", int_addr, 32'h0000_0100);
        pulse_ack();
        pulse_eoi();
        steps(2);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            done    = done ^ N'($urandom_range(0, 15) & ($urandom_range(0, 3) == 0 ? 15 : 0));
            int_ack = ($urandom_range(0, 3) == 0);
            eoi     = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 199) != 0);
`ifdef INT_REQ_MASK_EN
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = N'($urandom_range(0, 15));
`endif
            step();
        end
        reset = 1'b1; int_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
        steps(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
